// File: rtl/conv_mdc_kernel_stub_if.sv
// rtl/conv_mdc_kernel_stub_if.sv - ap_ctrl_hs control plus src/dst AXI-Stream bundle
// master drives start/dims/src beats; slave is the kernel responder.
interface conv_mdc_kernel_stub_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_idle;
  logic [31:0]           width;
  logic [31:0]           height;
  logic [DATA_WIDTH-1:0] src_V_TDATA;
  logic                  src_V_TVALID;
  logic                  src_V_TREADY;
  logic [DATA_WIDTH-1:0] dst_V_TDATA;
  logic                  dst_V_TVALID;
  logic                  dst_V_TREADY;

  modport master (
    output ap_start, width, height, src_V_TDATA, src_V_TVALID, dst_V_TREADY,
    input  ap_ready, ap_done, ap_idle, src_V_TREADY, dst_V_TDATA, dst_V_TVALID
  );

  modport slave (
    input  ap_start, width, height, src_V_TDATA, src_V_TVALID, dst_V_TREADY,
    output ap_ready, ap_done, ap_idle, src_V_TREADY, dst_V_TDATA, dst_V_TVALID
  );
endinterface

// File: rtl/conv_mdc_kernel_stub.sv
// rtl/conv_mdc_kernel_stub.sv - conv_mdc kernel stand-in: dst = src + BIAS per frame
// Accepts width*height words per frame and returns each through a small output FIFO.
module conv_mdc_kernel_stub #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BIAS       = 1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  conv_mdc_kernel_stub_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state, state_n;
  logic [31:0]           n_q, in_cnt, out_cnt, frame_len;
  logic [AW:0]           count;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  push, pop, fifo_full;
  logic                  latch_n, ready_n, done_n;
  logic                  ap_ready_q, ap_done_q, ap_idle_q;
  logic                  unused_hi;

  assign frame_len = {16'd0, bus.width[15:0]} * {16'd0, bus.height[15:0]};
  assign unused_hi = ^{bus.width[31:16], bus.height[31:16]};

  // No pop bypass: a full FIFO blocks input even if it drains this cycle.
  assign fifo_full        = (count == (AW+1)'(FIFO_DEPTH));
  assign bus.src_V_TREADY = (state == RUN) && (in_cnt < n_q) && !fifo_full;
  assign bus.dst_V_TVALID = (count != '0);
  assign bus.dst_V_TDATA  = mem[rd_ptr];
  assign push             = bus.src_V_TVALID && bus.src_V_TREADY;
  assign pop              = bus.dst_V_TVALID && bus.dst_V_TREADY;

  assign bus.ap_ready = ap_ready_q;
  assign bus.ap_done  = ap_done_q;
  assign bus.ap_idle  = ap_idle_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch_n = 1'b0;
    ready_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.ap_start) begin
          latch_n = 1'b1;
          if (frame_len == 32'd0) begin
            state_n = DONE;
            ready_n = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (push && (in_cnt == n_q - 32'd1)) begin
          state_n = DRAIN;
          ready_n = 1'b1;
        end
        if (pop && (out_cnt == n_q - 32'd1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DRAIN: begin
        if (pop && (out_cnt == n_q - 32'd1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ap_ready_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      n_q        <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ap_ready_q <= ready_n;
      ap_done_q  <= done_n;
      ap_idle_q  <= (state_n == IDLE);
      if (latch_n) begin
        n_q     <= frame_len;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (push) in_cnt  <= in_cnt + 32'd1;
        if (pop)  out_cnt <= out_cnt + 32'd1;
      end
      if (push) begin
        mem[wr_ptr] <= bus.src_V_TDATA + DATA_WIDTH'(BIAS);
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mdc_kernel_stub.sv
// tb/tb_conv_mdc_kernel_stub.sv - scoreboard bench for conv_mdc_kernel_stub
// Driver queues hand-computed results on each accepted beat; a negedge monitor checks dst beats.
module tb_conv_mdc_kernel_stub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_mdc_kernel_stub_if #(.DATA_WIDTH(32)) bus ();

  conv_mdc_kernel_stub #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .BIAS(1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          accepts = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          idle_cycles = 0;
  bit          tready_seen = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dst_V_TVALID && bus.dst_V_TREADY) begin
        beats++;
        if (exp_q.size() == 0) check("dst_unexpected_beat", bus.dst_V_TDATA, 32'hxxxx_xxxx);
        else                   check("dst_data", bus.dst_V_TDATA, exp_q.pop_front());
      end
      if (bus.src_V_TREADY) tready_seen = 1'b1;
      if (bus.ap_done)      done_cnt++;
      if (bus.ap_idle)      idle_cycles++;
    end
  end

  task automatic send(input logic [31:0] d, input logic [31:0] e);
    int n = 0;
    bus.src_V_TDATA  = d;
    bus.src_V_TVALID = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.src_V_TREADY && n < 100);
    if (!bus.src_V_TREADY) begin
      check("src_accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      accepts++;
    end
    @(posedge clk);
    #1;
    bus.src_V_TVALID = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] w, input logic [31:0] h);
    bus.width    = w;
    bus.height   = h;
    bus.ap_start = 1'b1;
    @(posedge clk);
    #1;
    bus.ap_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ap_done && n < 300);
    check("ap_done_seen", {31'd0, bus.ap_done}, 32'd1);
  endtask

  int d0, b0;

  initial begin
    bus.ap_start     = 1'b0;
    bus.width        = '0;
    bus.height       = '0;
    bus.src_V_TDATA  = '0;
    bus.src_V_TVALID = 1'b0;
    bus.dst_V_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ap_idle",  {31'd0, bus.ap_idle},      32'd1);
    check("rst_ap_ready", {31'd0, bus.ap_ready},     32'd0);
    check("rst_ap_done",  {31'd0, bus.ap_done},      32'd0);
    check("rst_tready",   {31'd0, bus.src_V_TREADY}, 32'd0);
    check("rst_tvalid",   {31'd0, bus.dst_V_TVALID}, 32'd0);
    check("rst_tdata",    bus.dst_V_TDATA,           32'd0);

    // 2x2 frame, sink always ready
    bus.dst_V_TREADY = 1'b1;
    start_frame(32'd2, 32'd2);
    check("t1_idle_fell", {31'd0, bus.ap_idle}, 32'd0);
    send(32'd10, 32'd11);
    send(32'd20, 32'd21);
    send(32'd30, 32'd31);
    send(32'd40, 32'd41);
    check("t1_ap_ready_pulse", {31'd0, bus.ap_ready},     32'd1);
    check("t1_tready_dropped", {31'd0, bus.src_V_TREADY}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_ap_ready_one_cycle", {31'd0, bus.ap_ready}, 32'd0);
    wait_done();
    check("t1_idle_in_done", {31'd0, bus.ap_idle}, 32'd0);
    @(negedge clk);
    check("t1_idle_after", {31'd0, bus.ap_idle}, 32'd1);
    check("t1_done_one_cycle", {31'd0, bus.ap_done}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // N=8 with the sink stalled for 10 cycles: FIFO fills at 4
    bus.dst_V_TREADY = 1'b0;
    accepts = 0;
    start_frame(32'd4, 32'd2);
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i * 10), 32'(i * 10 + 1));
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i >= 6) begin
            check("t2_tvalid_stall", {31'd0, bus.dst_V_TVALID}, 32'd1);
            check("t2_tdata_stable", bus.dst_V_TDATA, 32'd11);
          end
        end
        check("t2_accepts_when_full", accepts, 32'd4);
        check("t2_tready_full", {31'd0, bus.src_V_TREADY}, 32'd0);
        @(posedge clk);
        #1;
        bus.dst_V_TREADY = 1'b1;
      end
    join
    wait_done();
    @(negedge clk);
    check("t2_accepts_total", accepts, 32'd8);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // zero-size frame
    tready_seen = 1'b0;
    b0 = beats;
    start_frame(32'd0, 32'd5);
    check("t3_ap_ready", {31'd0, bus.ap_ready}, 32'd1);
    check("t3_ap_done",  {31'd0, bus.ap_done},  32'd1);
    repeat (4) @(negedge clk);
    check("t3_no_tready", {31'd0, tready_seen}, 32'd0);
    check("t3_no_beats", beats - b0, 32'd0);
    check("t3_idle", {31'd0, bus.ap_idle}, 32'd1);

    // back-to-back N=3 frames with ap_start held
    bus.width    = 32'd3;
    bus.height   = 32'd1;
    bus.ap_start = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles = 0;
    d0 = done_cnt;
    send(32'd1, 32'd2);
    send(32'd2, 32'd3);
    send(32'd3, 32'd4);
    wait_done();
    send(32'd4, 32'd5);
    send(32'd5, 32'd6);
    send(32'd6, 32'd7);
    wait_done();
    bus.ap_start = 1'b0;
    check("t4_never_idle", idle_cycles, 32'd0);
    @(negedge clk);
    check("t4_done_pulses", done_cnt - d0, 32'd2);
    check("t4_idle_after", {31'd0, bus.ap_idle}, 32'd1);

    // wraparound of the bias add
    start_frame(32'd2, 32'd1);
    send(32'hFFFF_FFFF, 32'h0000_0000);
    send(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done();
    @(negedge clk);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // reset mid-frame
    bus.dst_V_TREADY = 1'b0;
    start_frame(32'd2, 32'd2);
    send(32'd100, 32'd101);
    send(32'd200, 32'd201);
    rst_n = 1'b0;
    #1;
    check("t6_idle",   {31'd0, bus.ap_idle},      32'd1);
    check("t6_ready",  {31'd0, bus.ap_ready},     32'd0);
    check("t6_done",   {31'd0, bus.ap_done},      32'd0);
    check("t6_tready", {31'd0, bus.src_V_TREADY}, 32'd0);
    check("t6_tvalid", {31'd0, bus.dst_V_TVALID}, 32'd0);
    check("t6_tdata",  bus.dst_V_TDATA,           32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.dst_V_TREADY = 1'b1;
    @(posedge clk);
    #1;
    check("t6_fifo_empty", {31'd0, bus.dst_V_TVALID}, 32'd0);
    b0 = beats;
    start_frame(32'd2, 32'd2);
    send(32'd1, 32'd2);
    send(32'd2, 32'd3);
    send(32'd3, 32'd4);
    send(32'd4, 32'd5);
    wait_done();
    @(negedge clk);
    check("t6_beats", beats - b0, 32'd4);
    check("t6_queue_empty", exp_q.size(), 32'd0);
    check("t6_idle_after", {31'd0, bus.ap_idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
